// File: rtl/pipe_sel_stage_if.sv
// ============================================================================
// pipe_sel_stage_if : handshake/data bundle for the operand-select stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_sel_stage_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] data_i;
    logic [SEL_W-1:0]        select_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [WIDTH-1:0]        data_o;
    logic                    flush_i;
    logic                    sel_err_o;
    logic                    sel_err_clr_i;

    modport master (
        output data_i, select_i, in_valid_i, out_ready_i, flush_i, sel_err_clr_i,
        input  in_ready_o, out_valid_o, data_o, sel_err_o
    );

    modport slave (
        input  data_i, select_i, in_valid_i, out_ready_i, flush_i, sel_err_clr_i,
        output in_ready_o, out_valid_o, data_o, sel_err_o
    );
endinterface

`default_nettype wire

// File: rtl/pipe_sel_stage.sv
// ============================================================================
// pipe_sel_stage : N:1 operand select registered behind a 2-entry skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_sel_stage #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter int               SEL_MODE    = 0,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    pipe_sel_stage_if.slave bus
);
    localparam int SEL_W = (SEL_MODE == 0) ? $clog2(NUM_IN) : NUM_IN;

    logic [WIDTH-1:0] sel_word;
    logic             sel_legal;

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             sel_err;

    logic             accept;
    logic             pop;

    generate
        if (SEL_MODE == 0) begin : g_bin
            always_comb begin
                sel_word  = DEFAULT_VAL;
                sel_legal = 1'b0;
                for (int k = 0; k < NUM_IN; k++) begin
                    if (bus.select_i == SEL_W'(k)) begin
                        sel_word  = bus.data_i[k*WIDTH +: WIDTH];
                        sel_legal = 1'b1;
                    end
                end
            end
        end else begin : g_onehot
            logic [WIDTH-1:0] or_word;
            int               hits;
            always_comb begin
                or_word = '0;
                hits    = 0;
                for (int k = 0; k < NUM_IN; k++) begin
                    if (bus.select_i[k]) begin
                        or_word = or_word | bus.data_i[k*WIDTH +: WIDTH];
                        hits    = hits + 1;
                    end
                end
                sel_legal = (hits == 1);
                sel_word  = sel_legal ? or_word : DEFAULT_VAL;
            end
        end
    endgenerate

    assign accept = bus.in_valid_i && !skid_valid;
    assign pop    = main_valid && bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            sel_err    <= 1'b0;
        end else begin
            if (bus.flush_i) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
                main_data  <= '0;
            end else if (pop && skid_valid) begin
                // Upstream is stalled whenever skid is full, so no accept here.
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (pop) begin
                main_valid <= accept;
                if (accept) main_data <= sel_word;
            end else if (accept) begin
                if (main_valid) begin
                    skid_data  <= sel_word;
                    skid_valid <= 1'b1;
                end else begin
                    main_data  <= sel_word;
                    main_valid <= 1'b1;
                end
            end

            if (accept && !sel_legal && !bus.flush_i) sel_err <= 1'b1;
            else if (bus.sel_err_clr_i)               sel_err <= 1'b0;
        end
    end

    assign bus.data_o      = main_data;
    assign bus.out_valid_o = main_valid;
    assign bus.in_ready_o  = !skid_valid;
    assign bus.sel_err_o   = sel_err;
endmodule

`default_nettype wire

// File: tb/tb_pipe_sel_stage.sv
// ============================================================================
// tb_pipe_sel_stage : scoreboard + directed bench for three stage configurations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_sel_stage;
    localparam int               W    = 32;
    localparam logic [W-1:0]     DEF1 = 32'hDEAD_0001;
    localparam logic [W-1:0]     DEF2 = 32'hDEAD_0002;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_sel_stage_if #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) b0 ();
    pipe_sel_stage_if #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) b1 ();
    pipe_sel_stage_if #(.WIDTH(W), .NUM_IN(4), .SEL_W(4)) b2 ();

    pipe_sel_stage #(.WIDTH(W), .NUM_IN(4), .SEL_MODE(0), .DEFAULT_VAL(32'h0))
        u_bin4 (.clk_i(clk), .rst_i(rst_n), .bus(b0.slave));
    pipe_sel_stage #(.WIDTH(W), .NUM_IN(3), .SEL_MODE(0), .DEFAULT_VAL(DEF1))
        u_bin3 (.clk_i(clk), .rst_i(rst_n), .bus(b1.slave));
    pipe_sel_stage #(.WIDTH(W), .NUM_IN(4), .SEL_MODE(1), .DEFAULT_VAL(DEF2))
        u_oh4  (.clk_i(clk), .rst_i(rst_n), .bus(b2.slave));

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] words0 [4];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words0(input logic [W-1:0] w0, w1, w2, w3);
        words0[0] = w0; words0[1] = w1; words0[2] = w2; words0[3] = w3;
        for (int k = 0; k < 4; k++) b0.data_i[k*W +: W] = words0[k];
    endtask

    // Compare b0 against the queue model, then advance one edge and update the model.
    task automatic step0(output bit acc);
        bit           pop, fl;
        logic [W-1:0] exp_word;
        check("b0_out_valid", b0.out_valid_o, q.size() > 0);
        check("b0_in_ready",  b0.in_ready_o,  q.size() < 2);
        check("b0_sel_err",   b0.sel_err_o,   1'b0);
        if (q.size() > 0) check("b0_data", b0.data_o, q[0]);
        acc      = b0.in_valid_i && (q.size() < 2) && !b0.flush_i;
        pop      = (q.size() > 0) && b0.out_ready_i;
        fl       = b0.flush_i;
        exp_word = words0[b0.select_i];
        tick();
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(exp_word);
        end
    endtask

    initial begin
        bit acc;
        int beat;
        b0.data_i = '0; b0.select_i = '0; b0.in_valid_i = 0; b0.out_ready_i = 0;
        b0.flush_i = 0; b0.sel_err_clr_i = 0;
        b1.data_i = {32'h1112, 32'h1111, 32'h1110};
        b1.select_i = '0; b1.in_valid_i = 0; b1.out_ready_i = 0;
        b1.flush_i = 0; b1.sel_err_clr_i = 0;
        b2.data_i = {32'h2223, 32'h2222, 32'h2221, 32'h2220};
        b2.select_i = '0; b2.in_valid_i = 0; b2.out_ready_i = 0;
        b2.flush_i = 0; b2.sel_err_clr_i = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        check("rst_data",      b0.data_o,      '0);
        check("rst_out_valid", b0.out_valid_o, 1'b0);
        check("rst_in_ready",  b0.in_ready_o,  1'b1);
        check("rst_sel_err",   b1.sel_err_o,   1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Select 2 with out_ready high: C2 visible after one edge
        set_words0(32'hA0, 32'hB1, 32'hC2, 32'hD3);
        b0.out_ready_i = 1; b0.select_i = 2'd2; b0.in_valid_i = 1;
        step0(acc);
        b0.in_valid_i = 0;
        check("t1_data_c2", b0.data_o, 32'hC2);
        step0(acc);
        step0(acc);

        // Four beats against a stalled sink, sink releases on cycle 4
        b0.out_ready_i = 0;
        beat = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 4) b0.out_ready_i = 1;
            if (beat < 4) begin
                b0.in_valid_i = 1;
                b0.select_i   = beat[1:0];
                set_words0(32'h100*beat + 0, 32'h100*beat + 1, 32'h100*beat + 2, 32'h100*beat + 3);
            end else b0.in_valid_i = 0;
            step0(acc);
            if (acc) beat++;
            if (cyc == 1) check("t2_in_ready_low", b0.in_ready_o, 1'b0);
        end
        check("t2_all_beats_taken", beat[W-1:0], 32'd4);

        // Random valid/ready/data traffic
        for (int cyc = 0; cyc < 60; cyc++) begin
            b0.in_valid_i  = 1'($urandom_range(0, 1));
            b0.out_ready_i = 1'($urandom_range(0, 1));
            b0.select_i    = 2'($urandom_range(0, 3));
            set_words0($urandom, $urandom, $urandom, $urandom);
            step0(acc);
        end
        b0.in_valid_i = 0; b0.out_ready_i = 1;
        step0(acc); step0(acc); step0(acc);

        // Binary NUM_IN=3: select 3 is illegal, error is sticky until cleared
        b1.out_ready_i = 1; b1.select_i = 2'd3; b1.in_valid_i = 1;
        tick();
        b1.in_valid_i = 0;
        check("t3_default",    b1.data_o,      DEF1);
        check("t3_valid",      b1.out_valid_o, 1'b1);
        check("t3_err_set",    b1.sel_err_o,   1'b1);
        tick();
        check("t3_err_sticky", b1.sel_err_o,   1'b1);
        check("t3_popped",     b1.out_valid_o, 1'b0);
        b1.sel_err_clr_i = 1;
        tick();
        b1.sel_err_clr_i = 0;
        check("t3_err_clr",    b1.sel_err_o,   1'b0);
        b1.select_i = 2'd3; b1.in_valid_i = 1; b1.sel_err_clr_i = 1;
        tick();
        b1.in_valid_i = 0; b1.sel_err_clr_i = 0;
        check("t3_set_wins",   b1.sel_err_o,   1'b1);
        b1.sel_err_clr_i = 1; b1.select_i = 2'd1; b1.in_valid_i = 1;
        tick();
        b1.in_valid_i = 0; b1.sel_err_clr_i = 0;
        check("t3_legal_data", b1.data_o,      32'h1111);
        check("t3_legal_noerr", b1.sel_err_o,  1'b0);
        tick();

        // Both entries full, flush with an illegal beat offered
        b1.out_ready_i = 0; b1.in_valid_i = 1;
        b1.select_i = 2'd0; tick();
        b1.select_i = 2'd2; tick();
        check("t5_full_ready", b1.in_ready_o,  1'b0);
        check("t5_full_data",  b1.data_o,      32'h1110);
        b1.select_i = 2'd3; b1.flush_i = 1;
        tick();
        b1.flush_i = 0; b1.in_valid_i = 0;
        check("t5_valid",      b1.out_valid_o, 1'b0);
        check("t5_ready",      b1.in_ready_o,  1'b1);
        check("t5_data",       b1.data_o,      '0);
        check("t5_err_kept0",  b1.sel_err_o,   1'b0);
        b1.in_valid_i = 1; b1.select_i = 2'd3; b1.out_ready_i = 1;
        tick();
        b1.in_valid_i = 0; b1.flush_i = 1;
        tick();
        b1.flush_i = 0;
        check("t5_err_kept1",  b1.sel_err_o,   1'b1);

        // One-hot: two bits and zero bits are illegal
        b2.out_ready_i = 1; b2.in_valid_i = 1; b2.select_i = 4'b0110;
        tick();
        check("t4_default",    b2.data_o,      DEF2);
        check("t4_err",        b2.sel_err_o,   1'b1);
        b2.in_valid_i = 0; b2.sel_err_clr_i = 1;
        tick();
        b2.sel_err_clr_i = 0; b2.in_valid_i = 1; b2.select_i = 4'b0100;
        tick();
        check("t4_in2",        b2.data_o,      32'h2222);
        check("t4_noerr",      b2.sel_err_o,   1'b0);
        b2.select_i = 4'b1000;
        tick();
        check("t4_in3",        b2.data_o,      32'h2223);
        b2.select_i = 4'b0000;
        tick();
        b2.in_valid_i = 0;
        check("t4_zero_def",   b2.data_o,      DEF2);
        check("t4_zero_err",   b2.sel_err_o,   1'b1);

        // Async reset between edges with both b0 entries full
        b0.out_ready_i = 0; b0.in_valid_i = 1;
        set_words0(32'h51, 32'h52, 32'h53, 32'h54);
        b0.select_i = 2'd0; step0(acc);
        b0.select_i = 2'd3; step0(acc);
        b0.in_valid_i = 0;
        check("t6_full", b0.in_ready_o, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", b0.out_valid_o, 1'b0);
        check("t6_rst_ready", b0.in_ready_o,  1'b1);
        check("t6_rst_data",  b0.data_o,      '0);
        check("t6_rst_err",   b2.sel_err_o,   1'b0);
        q.delete();
        tick();
        @(negedge clk) rst_n = 1'b1;
        b0.out_ready_i = 1; b0.in_valid_i = 1;
        set_words0(32'h61, 32'h62, 32'h63, 32'h64);
        b0.select_i = 2'd1; step0(acc);
        b0.select_i = 2'd2; step0(acc);
        b0.in_valid_i = 0;
        step0(acc); step0(acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
